// File: rtl/rv_pkg.sv
// Shared core types: IF control bundle, fetch constants and hold-buffer state.
// Imported by rv_fetch, rv_next_pc and rv_ctrl.
package rv_pkg;

  typedef struct packed {
    logic ready_Q100H;
    logic ready_Q101H;
    logic sel_next_pc_alu_out_Q102H;
  } t_if_ctrl;

  // ADDI x0,x0,0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } t_hold_state;

  function automatic logic [31:0] rv_align4(
    input logic [31:0] addr
  );
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv_next_pc.sv
// Next fetch PC select: redirect target > hold on stall > pc+4 (mod 2^32).
// Ports: pc_Q100H, redirect, ready_Q100H, alu_out_Q102H in; next_pc out.
module rv_next_pc
  import rv_pkg::*;
(
  input  logic [31:0] pc_Q100H,
  input  logic        redirect,
  input  logic        ready_Q100H,
  input  logic [31:0] alu_out_Q102H,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc_Q100H + 32'd4;
    if (redirect) begin
      next_pc = rv_align4(alu_out_Q102H);
    end else if (!ready_Q100H) begin
      next_pc = pc_Q100H;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/rv_fetch.sv
// Fetch stage Q100H->Q101H: PC register, imem drive, 1-entry hold buffer, squash.
// Ports: clk, rst (sync, high), if_ctrl, alu_out_Q102H, imem_rd_data_Q101H in;
//   imem_rd_en/addr_Q100H, pc_Q100H, pc_Q101H, instruction_Q101H, valid_Q101H out.
// RV_FETCH_PERF_CNT_EN adds perf_fetch_cnt, perf_squash_cnt, perf_stall_cnt.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  t_if_ctrl    if_ctrl,
  input  logic [31:0] alu_out_Q102H,
  input  logic [31:0] imem_rd_data_Q101H,
  output logic        imem_rd_en_Q100H,
  output logic [31:0] imem_rd_addr_Q100H,
  output logic [31:0] pc_Q100H,
  output logic [31:0] pc_Q101H,
  output logic [31:0] instruction_Q101H,
  output logic        valid_Q101H
`ifdef RV_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic        redirect;
  logic        rdy0;
  logic        rdy1;
  logic [31:0] next_pc;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc1_q;
  logic [31:0] pc1_d;
  logic        valid_q;
  logic        valid_d;
  t_hold_state hold_q;
  t_hold_state hold_d;
  logic [31:0] buf_q;
  logic [31:0] buf_d;
  logic        squash;

  assign redirect = if_ctrl.sel_next_pc_alu_out_Q102H;
  assign rdy0     = if_ctrl.ready_Q100H;
  assign rdy1     = if_ctrl.ready_Q101H;

  rv_next_pc u_next_pc (
    .pc_Q100H      (pc_q),
    .redirect      (redirect),
    .ready_Q100H   (rdy0),
    .alu_out_Q102H (alu_out_Q102H),
    .next_pc       (next_pc)
  );

  assign imem_rd_en_Q100H   = !rst && (rdy0 || redirect);
  assign imem_rd_addr_Q100H = pc_q;
  assign pc_Q100H           = pc_q;
  assign pc_Q101H           = pc1_q;

  always_comb begin
    pc_d  = next_pc;
    pc1_d = pc1_q;
    valid_d = valid_q;
    // Redirect must advance Q101H even under stall so the
    // wrong-path slot behind it is marked dead.
    if (rdy1 || redirect) begin
      pc1_d   = pc_q;
      valid_d = imem_rd_en_Q100H && !redirect;
    end
  end

  always_comb begin
    hold_d = hold_q;
    buf_d  = buf_q;
    unique case (hold_q)
      HOLD_EMPTY: begin
        // imem only presents the word for one cycle; keep it.
        if (!rdy1 && valid_q && !redirect) begin
          hold_d = HOLD_HELD;
          buf_d  = imem_rd_data_Q101H;
        end
      end
      HOLD_HELD: begin
        if (rdy1 || redirect) begin
          hold_d = HOLD_EMPTY;
        end
      end
      default: hold_d = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc1_q   <= 32'h0;
      valid_q <= 1'b0;
      hold_q  <= HOLD_EMPTY;
      buf_q   <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      buf_q   <= buf_d;
    end
  end

  assign squash      = redirect || !valid_q;
  assign valid_Q101H = valid_q && !redirect;

  always_comb begin
    if (squash) begin
      instruction_Q101H = NOP_INSTR;
    end else if (hold_q == HOLD_HELD) begin
      instruction_Q101H = buf_q;
    end else begin
      instruction_Q101H = imem_rd_data_Q101H;
    end
  end

`ifdef RV_FETCH_PERF_CNT_EN
  logic [31:0] fetch_q;
  logic [31:0] fetch_d;
  logic [31:0] sq_q;
  logic [31:0] sq_d;
  logic [31:0] stall_q;
  logic [31:0] stall_d;
  logic        post_redir_q;

  always_comb begin
    fetch_d = fetch_q;
    sq_d    = sq_q;
    stall_d = stall_q;
    // Count each instruction once, on the cycle decode takes it.
    if (valid_Q101H && rdy1) fetch_d = fetch_q + 32'd1;
    if (redirect || post_redir_q) sq_d = sq_q + 32'd1;
    if (!rdy0) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q      <= 32'h0;
      sq_q         <= 32'h0;
      stall_q      <= 32'h0;
      post_redir_q <= 1'b0;
    end else begin
      fetch_q      <= fetch_d;
      sq_q         <= sq_d;
      stall_q      <= stall_d;
      post_redir_q <= redirect;
    end
  end

  assign perf_fetch_cnt  = fetch_q;
  assign perf_squash_cnt = sq_q;
  assign perf_stall_cnt  = stall_q;
`endif

  a_stall_order: assert property (
    @(posedge clk) disable iff (rst)
      !(!rdy1 && rdy0)
  );

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: slot-level reference model + directed literal checks.
// Second instance exercises PC wrap from RESET_PC=0xFFFF_FFF8.
module tb_rv_fetch;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  t_if_ctrl    if_ctrl;
  logic [31:0] alu;
  logic [31:0] imem_q;
  logic [31:0] w_imem_q;

  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] pc0;
  logic [31:0] pc1;
  logic [31:0] instr;
  logic        valid;

  logic        w_rd_en;
  logic [31:0] w_rd_addr;
  logic [31:0] w_pc0;
  logic [31:0] w_pc1;
  logic [31:0] w_instr;
  logic        w_valid;

`ifdef RV_FETCH_PERF_CNT_EN
  logic [31:0] p_fetch;
  logic [31:0] p_sq;
  logic [31:0] p_stall;
  logic [31:0] wp_fetch;
  logic [31:0] wp_sq;
  logic [31:0] wp_stall;
`endif

  int checks = 0;
  int errors = 0;

  rv_fetch u_dut (
    .clk                (clk),
    .rst                (rst),
    .if_ctrl            (if_ctrl),
    .alu_out_Q102H      (alu),
    .imem_rd_data_Q101H (imem_q),
    .imem_rd_en_Q100H   (rd_en),
    .imem_rd_addr_Q100H (rd_addr),
    .pc_Q100H           (pc0),
    .pc_Q101H           (pc1),
    .instruction_Q101H  (instr),
    .valid_Q101H        (valid)
`ifdef RV_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt     (p_fetch),
    .perf_squash_cnt    (p_sq),
    .perf_stall_cnt     (p_stall)
`endif
  );

  rv_fetch #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_wrap (
    .clk                (clk),
    .rst                (rst),
    .if_ctrl            (if_ctrl),
    .alu_out_Q102H      (alu),
    .imem_rd_data_Q101H (w_imem_q),
    .imem_rd_en_Q100H   (w_rd_en),
    .imem_rd_addr_Q100H (w_rd_addr),
    .pc_Q100H           (w_pc0),
    .pc_Q101H           (w_pc1),
    .instruction_Q101H  (w_instr),
    .valid_Q101H        (w_valid)
`ifdef RV_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt     (wp_fetch),
    .perf_squash_cnt    (wp_sq),
    .perf_stall_cnt     (wp_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem word i holds i; a cycle without a read returns junk.
  always @(posedge clk) begin
    imem_q   <= rd_en ? (rd_addr >> 2) : 32'hBAD0_BAD0;
    w_imem_q <= w_rd_en ? (w_rd_addr >> 2) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: fetch PC plus one decode slot {valid, pc, word}.
  logic [31:0] m_pc;
  logic [31:0] m_pc1;
  logic        m_valid;
  logic [31:0] m_word;
  logic        m_live = 1'b0;
  logic        m_prev_redir;
  logic [31:0] m_fetch;
  logic [31:0] m_sq;
  logic [31:0] m_stall;

  always @(posedge clk) begin
    logic r0;
    logic r1;
    logic rd;
    r0 = if_ctrl.ready_Q100H;
    r1 = if_ctrl.ready_Q101H;
    rd = if_ctrl.sel_next_pc_alu_out_Q102H;
    if (rst) begin
      m_pc = 32'h0;
      m_pc1 = 32'h0;
      m_valid = 1'b0;
      m_word = NOP;
      m_prev_redir = 1'b0;
      m_fetch = 0;
      m_sq = 0;
      m_stall = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_valid && !rd && r1) m_fetch = m_fetch + 1;
      if (rd || m_prev_redir) m_sq = m_sq + 1;
      if (!r0) m_stall = m_stall + 1;
      m_prev_redir = rd;
      if (r1 || rd) begin
        m_pc1 = m_pc;
        m_valid = r0 && !rd;
        m_word = m_pc >> 2;
      end
      if (rd) m_pc = alu & 32'hFFFF_FFFC;
      else if (r0) m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    logic ev;
    if (m_live) begin
      ev = m_valid && !if_ctrl.sel_next_pc_alu_out_Q102H;
      chk("m_pc0", pc0, m_pc);
      chk("m_addr", rd_addr, m_pc);
      chk("m_pc1", pc1, m_pc1);
      chk("m_valid", {31'b0, valid}, {31'b0, ev});
      chk("m_instr", instr, ev ? m_word : NOP);
      chk("m_rden", {31'b0, rd_en},
          {31'b0, !rst && (if_ctrl.ready_Q100H ||
                           if_ctrl.sel_next_pc_alu_out_Q102H)});
`ifdef RV_FETCH_PERF_CNT_EN
      chk("m_pfetch", p_fetch, m_fetch);
      chk("m_psq", p_sq, m_sq);
      chk("m_pstall", p_stall, m_stall);
`endif
    end
  end

  task automatic set(input logic r0, input logic r1, input logic rd,
                     input logic [31:0] a);
    if_ctrl.ready_Q100H = r0;
    if_ctrl.ready_Q101H = r1;
    if_ctrl.sel_next_pc_alu_out_Q102H = rd;
    alu = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set(1, 1, 0, 0);
    tick();
    tick();
    chk("rst_pc", pc0, 32'h0);
    chk("rst_pc1", pc1, 32'h0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_rden", {31'b0, rd_en}, 0);
    chk("rst_wpc", w_pc0, 32'hFFFF_FFF8);

    rst = 1'b0;
    set(1, 1, 0, 0);
    chk("c0_rden", {31'b0, rd_en}, 1);
    chk("c0_pc", pc0, 32'h0);
    chk("c0_instr", instr, NOP);
    chk("w0_pc", w_pc0, 32'hFFFF_FFF8);
    tick();
    chk("c1_pc", pc0, 32'h4);
    chk("c1_valid", {31'b0, valid}, 1);
    chk("c1_instr", instr, 32'h0);
    chk("w1_pc", w_pc0, 32'hFFFF_FFFC);
    tick();
    chk("c2_pc", pc0, 32'h8);
    chk("c2_instr", instr, 32'h1);
    chk("w2_pc", w_pc0, 32'h0);
    tick();
    chk("c3_pc", pc0, 32'hC);
    chk("c3_instr", instr, 32'h2);
    chk("w3_pc", w_pc0, 32'h4);
    tick();

    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 0);
      chk("st_pc", pc0, 32'h10);
      chk("st_instr", instr, 32'h3);
      chk("st_valid", {31'b0, valid}, 1);
      chk("st_pc1", pc1, 32'hC);
      tick();
    end
    set(1, 1, 0, 0);
    chk("st_rel_instr", instr, 32'h3);
    chk("st_rel_pc", pc0, 32'h10);
    tick();
    chk("st_nxt_instr", instr, 32'h4);
    chk("st_nxt_pc1", pc1, 32'h10);
    tick();

    set(0, 1, 0, 0);
    chk("bub_instr", instr, 32'h5);
    tick();
    set(1, 1, 0, 0);
    chk("bub_valid", {31'b0, valid}, 0);
    chk("bub_nop", instr, NOP);
    chk("bub_pc", pc0, 32'h18);
    tick();
    tick();

    set(1, 1, 1, 32'h103);
    chk("rd_pc", pc0, 32'h20);
    chk("rd_valid", {31'b0, valid}, 0);
    chk("rd_nop", instr, NOP);
    tick();
    set(1, 1, 0, 0);
    chk("rd1_pc", pc0, 32'h100);
    chk("rd1_valid", {31'b0, valid}, 0);
    chk("rd1_nop", instr, NOP);
    tick();
    chk("rd2_pc", pc0, 32'h104);
    chk("rd2_instr", instr, 32'h40);
    chk("rd2_pc1", pc1, 32'h100);
`ifdef RV_FETCH_PERF_CNT_EN
    chk("perf_sq2", p_sq, 32'd2);
`endif
    tick();

    set(0, 0, 0, 0);
    chk("rs_instr", instr, 32'h41);
    tick();
    set(0, 0, 1, 32'h200);
    chk("rs_nop", instr, NOP);
    tick();
    set(0, 0, 0, 0);
    chk("rs_pc", pc0, 32'h200);
    chk("rs_valid", {31'b0, valid}, 0);
    tick();
    set(1, 1, 0, 0);
    chk("rs_rel_pc", pc0, 32'h200);
    tick();
    chk("rs_instr2", instr, 32'h80);
    chk("rs_pc1", pc1, 32'h200);
    tick();

    set(0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_pc", pc0, 32'h0);
    chk("mr_valid", {31'b0, valid}, 0);
    chk("mr_instr", instr, NOP);
`ifdef RV_FETCH_PERF_CNT_EN
    chk("mr_pfetch", p_fetch, 0);
    chk("mr_psq", p_sq, 0);
    chk("mr_pstall", p_stall, 0);
`endif
    set(1, 1, 1, 32'h300);
    tick();
    chk("mr_rd_pc", pc0, 32'h0);
    rst = 1'b0;
    set(1, 1, 0, 0);
    tick();
    tick();
    chk("end_pc", pc0, 32'h8);
    chk("end_instr", instr, 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
